bcd_serial_subtractor: RTL and testbench

- Digit-serial BCD subtractor. Computes A - B - bin over DIGITS packed BCD digits, one digit per clock, LSD first.
- Returns a sign-magnitude BCD result: magnitude digits plus a negative flag.
- Counterpart of the combinational BCD adder stage. Sits between switch/operand registers and the char7seg display decoders.
- Uses a start/busy/done handshake so a controller can sequence operations.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_digit_sub.sv | 18 +
 rtl/bcd_serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, radix, subtractor FSM states and digit validity check.
package bcd_pkg;
    localparam int DIGIT_W   = 4;
    localparam int BCD_RADIX = 10;

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} bcd_sub_state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return digit < DIGIT_W'(BCD_RADIX);
    endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of a - b - bi with borrow-out; purely combinational, no handshake.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bi,
    output logic [DIGIT_W-1:0] d,
    output logic               bo
);
    logic [DIGIT_W:0] t;

    always_comb begin
        t  = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bi};
        bo = t[DIGIT_W];
        d  = bo ? DIGIT_W'(t + (DIGIT_W+1)'(BCD_RADIX)) : t[DIGIT_W-1:0];
    end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial sign-magnitude BCD subtractor: DIGITS+1 cycles (2*DIGITS+1 if negative, 1 on bad digit).
// start is only accepted in IDLE; no queueing, so a controller must wait for done.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a_bcd,
    input  logic [DIGIT_W*DIGITS-1:0] b_bcd,
    input  logic                      bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] diff,
    output logic                      neg,
    output logic                      err
);
    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    bcd_sub_state_t     state;
    logic [W-1:0]       a_q, b_q, r_q, r_next;
    logic [IDX_W-1:0]   idx;
    logic               borrow;
    logic               ovf;
    logic               ops_ok, a_zero, b_max;
    logic [DIGIT_W-1:0] ds_a, ds_b, ds_d;
    logic               ds_bo;

    always_comb begin
        ops_ok = 1'b1;
        a_zero = 1'b1;
        b_max  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a_bcd[i*DIGIT_W +: DIGIT_W]) || !is_bcd(b_bcd[i*DIGIT_W +: DIGIT_W]))
                ops_ok = 1'b0;
            if (a_bcd[i*DIGIT_W +: DIGIT_W] != '0)
                a_zero = 1'b0;
            if (b_bcd[i*DIGIT_W +: DIGIT_W] != DIGIT_W'(BCD_RADIX - 1))
                b_max = 1'b0;
        end
    end

    // FIX reuses the same digit slice to ten's-complement the SUB result in place.
    always_comb begin
        ds_a = (state == FIX) ? '0 : a_q[DIGIT_W-1:0];
        ds_b = (state == FIX) ? r_q[DIGIT_W-1:0] : b_q[DIGIT_W-1:0];
    end

    bcd_digit_sub u_digit (
        .a  (ds_a),
        .b  (ds_b),
        .bi (borrow),
        .d  (ds_d),
        .bo (ds_bo)
    );

    // Result digits enter at the top so after DIGITS shifts the LSD sits at bit 0.
    always_comb begin
        r_next = r_q >> DIGIT_W;
        r_next[W-1 -: DIGIT_W] = ds_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q <= a_bcd;
                        b_q <= b_bcd;
                        if (!ops_ok) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            diff  <= '0;
                            neg   <= 1'b0;
                        end else begin
                            state  <= SUB;
                            busy   <= 1'b1;
                            idx    <= '0;
                            borrow <= bin;
                            r_q    <= '0;
                            // Only 0 - 99..9 - 1 reaches -10^DIGITS, which has no DIGITS-wide magnitude.
                            ovf    <= a_zero && b_max && bin;
                        end
                    end
                end
                SUB: begin
                    a_q    <= a_q >> DIGIT_W;
                    b_q    <= b_q >> DIGIT_W;
                    r_q    <= r_next;
                    borrow <= ds_bo;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx <= '0;
                        if (ds_bo) begin
                            state  <= FIX;
                            borrow <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            diff  <= r_next;
                            neg   <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                end
                FIX: begin
                    r_q    <= r_next;
                    borrow <= ds_bo;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= ovf ? '0 : r_next;
                        neg   <= 1'b1;
                        err   <= ovf;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed scoreboard bench for bcd_serial_subtractor with DIGITS=2.
module tb_bcd_serial_subtractor;
    localparam int DIGITS = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bin   = 1'b0;
    logic [7:0] a_bcd = '0;
    logic [7:0] b_bcd = '0;
    logic       busy, done, neg, err;
    logic [7:0] diff;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_bcd (a_bcd),
        .b_bcd (b_bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] diff;
        logic       neg;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t req;
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with diff=%0h, expected no done (cycle %0d)", diff, cyc);
            end else begin
                req = sb.pop_front();
                chk("diff", 32'(diff), 32'(req.diff));
                chk("neg", 32'(neg), 32'(req.neg));
                chk("err", 32'(err), 32'(req.err));
                if (req.due >= 0) chk("done_cycle", 32'(cyc), 32'(req.due));
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic en, input logic ee,
                          input int n, input bit timing, input bit poke);
        int t0, bc, k, dc0;
        @(negedge clk); #1;
        a_bcd = a; b_bcd = b; bin = bi; start = 1'b1;
        t0  = cyc;
        dc0 = done_cnt;
        sb.push_back('{ed, en, ee, timing ? t0 + n : -1});
        bc = 0;
        k  = 0;
        do begin
            @(negedge clk); #1;
            start = poke && (k == 0);
            if (poke && k == 0) begin
                a_bcd = 8'h11; b_bcd = 8'h22; bin = 1'b0;
            end
            if (busy === 1'b1) bc++;
            k++;
        end while (done_cnt == dc0 && k < 40);
        start = 1'b0;
        if (done_cnt == dc0) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: got no done in 40 cycles, expected done (a=%0h b=%0h)", a, b);
            sb.delete();
        end
        if (timing) chk("busy_cycles", 32'(bc), 32'(n - 1));
    endtask

    initial begin
        int dc0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h42, 8'h17, 1'b0, 8'h25, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        run_op(8'h17, 8'h42, 1'b0, 8'h25, 1'b1, 1'b0, 5, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 5, 1'b1, 1'b0);
        run_op(8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        run_op(8'h20, 8'h01, 1'b1, 8'h18, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        run_op(8'h3A, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        run_op(8'h00, 8'h99, 1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0);

        // Second start in cycle 1 must be dropped; the held result stays 99.
        run_op(8'h99, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0, 3, 1'b1, 1'b1);
        dc0 = done_cnt;
        repeat (8) @(negedge clk);
        #1;
        chk("ignored_start_dones", 32'(done_cnt), 32'(dc0));
        chk("diff_held", 32'(diff), 32'h99);

        // Abort a negative operation in its FIX phase.
        @(negedge clk); #1;
        a_bcd = 8'h17; b_bcd = 8'h42; bin = 1'b0; start = 1'b1;
        dc0 = done_cnt;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_neg", 32'(neg), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(dc0));

        run_op(8'h50, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
